// File: rtl/ddr_cmd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// ddr_cmd_decoder_pkg
// Shared DDR4 command-decoder types and defaults.
//   command_type : decoded DDR4 command
//   err_type     : protocol violation code reported alongside a command
//   TRCD_DEFAULT : default ACT-to-CAS spacing in CK_t cycles
//   is_cas()     : true for column commands (RD/WR/RDA/WRA)
// -----------------------------------------------------------------------------
package ddr_cmd_decoder_pkg;

  localparam int TRCD_DEFAULT      = 11;
  localparam int NUM_BANKS_DEFAULT = 16;
  localparam int ROW_W             = 14;

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_DES,
    CMD_ACT,
    CMD_MRS,
    CMD_REF,
    CMD_PRE,
    CMD_PREA,
    CMD_WR,
    CMD_WRA,
    CMD_RD,
    CMD_RDA,
    CMD_ZQCL,
    CMD_ILLEGAL
  } command_type;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_ACT_OPEN,
    ERR_CAS_CLOSED,
    ERR_TRCD,
    ERR_REF_OPEN,
    ERR_ILLEGAL
  } err_type;

  function automatic logic is_cas(input command_type c);
    return (c == CMD_RD) || (c == CMD_RDA) || (c == CMD_WR) || (c == CMD_WRA);
  endfunction

endpackage

// File: rtl/ddr_cmd_decoder_bank_tracker.sv
// -----------------------------------------------------------------------------
// ddr_bank_tracker
// Per-bank state (open flag, open row, tRCD down-counter) and protocol checks.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_cmd          : decoded command for this cycle (combinational from pins)
//   i_bank         : {bg, ba} bank index
//   i_row          : row field captured on ACT
//   o_open_row     : open row of the addressed bank (combinational)
//   o_bank_open    : registered per-bank open flags
//   o_err_valid    : registered one-cycle violation pulse
//   o_err_code     : registered violation code (ERR_NONE when clean)
// -----------------------------------------------------------------------------
module ddr_bank_tracker
  import ddr_cmd_decoder_pkg::*;
#(
  parameter int TRCD      = TRCD_DEFAULT,
  parameter int NUM_BANKS = NUM_BANKS_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  command_type          i_cmd,
  input  logic [3:0]           i_bank,
  input  logic [ROW_W-1:0]     i_row,
  output logic [ROW_W-1:0]     o_open_row,
  output logic [NUM_BANKS-1:0] o_bank_open,
  output logic                 o_err_valid,
  output err_type              o_err_code
);

  localparam int CNT_W = $clog2(TRCD + 1);

  logic [NUM_BANKS-1:0] w_sel;
  logic [NUM_BANKS-1:0] w_open;
  logic [NUM_BANKS-1:0] w_busy;
  logic [ROW_W-1:0]     w_row_arr [NUM_BANKS];

  logic             w_sel_open;
  logic             w_sel_busy;
  logic [ROW_W-1:0] w_sel_row;
  err_type          w_err;
  logic             w_do_act;
  logic             w_do_close_sel;
  logic             w_do_close_all;

  logic    r_err_valid;
  err_type r_err_code;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic             r_open;
      logic [ROW_W-1:0] r_row;
      logic [CNT_W-1:0] r_cnt;

      assign w_sel[gi]     = (i_bank == 4'(gi));
      assign w_open[gi]    = r_open;
      assign w_busy[gi]    = (r_cnt != '0);
      assign w_row_arr[gi] = r_row;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_open <= 1'b0;
          r_row  <= '0;
          r_cnt  <= '0;
        end else if (w_sel[gi] && w_do_act) begin
          r_open <= 1'b1;
          r_row  <= i_row;
          r_cnt  <= CNT_W'(TRCD - 1);
        end else begin
          if (w_do_close_all || (w_sel[gi] && w_do_close_sel)) begin
            r_open <= 1'b0;
          end
          // Free-running countdown, parked at zero once tRCD has elapsed.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_sel_open = |(w_open & w_sel);
    w_sel_busy = |(w_busy & w_sel);
    w_sel_row  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_sel[b]) begin
        w_sel_row = w_row_arr[b];
      end
    end
  end

  always_comb begin
    w_err = ERR_NONE;
    case (i_cmd)
      CMD_ACT: begin
        if (w_sel_open) w_err = ERR_ACT_OPEN;
      end
      CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: begin
        if (!w_sel_open)     w_err = ERR_CAS_CLOSED;
        else if (w_sel_busy) w_err = ERR_TRCD;
      end
      CMD_REF, CMD_ZQCL: begin
        if (|w_open) w_err = ERR_REF_OPEN;
      end
      CMD_ILLEGAL: w_err = ERR_ILLEGAL;
      default:     w_err = ERR_NONE;
    endcase
  end

  // A rejected command must leave the table untouched, so ACT and
  // auto-precharge only take effect when no violation was flagged.
  assign w_do_act       = (i_cmd == CMD_ACT) && (w_err == ERR_NONE);
  assign w_do_close_sel = (i_cmd == CMD_PRE) ||
                          (((i_cmd == CMD_RDA) || (i_cmd == CMD_WRA)) && (w_err == ERR_NONE));
  assign w_do_close_all = (i_cmd == CMD_PREA);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_err_valid <= (w_err != ERR_NONE);
      r_err_code  <= w_err;
    end
  end

  assign o_open_row  = w_sel_row;
  assign o_bank_open = w_open;
  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;

endmodule

// File: rtl/ddr_cmd_decoder.sv
// -----------------------------------------------------------------------------
// ddr_cmd_decoder
// Decodes DDR4 command pins sampled on each rising CK_t into a registered
// command plus fields (latency 1), and tracks bank state for protocol checks.
// Ports:
//   CK_t, reset_n         : clock, synchronous active-low reset
//   cs_n .. A9_A0         : DDR4 command/address pins
//   cmd_valid, cmd        : decoded command (DES/NOP give cmd_valid=0)
//   bg_out .. bc_n_out    : decoded bank/row/column fields
//   mr_valid, mode_reg    : MRS pulse and payload
//   err_valid, err_code   : protocol violation for the reported command
//   bank_open             : per-bank open flags
// -----------------------------------------------------------------------------
module ddr_cmd_decoder
  import ddr_cmd_decoder_pkg::*;
#(
  parameter int TRCD      = TRCD_DEFAULT,
  parameter int NUM_BANKS = NUM_BANKS_DEFAULT
) (
  input  logic                 CK_t,
  input  logic                 reset_n,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic                 RAS_n_A16,
  input  logic                 CAS_n_A15,
  input  logic                 WE_n_A14,
  input  logic [1:0]           bg_addr,
  input  logic [1:0]           ba_addr,
  input  logic                 A17,
  input  logic                 A13,
  input  logic                 A12_BC_n,
  input  logic                 A11,
  input  logic                 A10_AP,
  input  logic [9:0]           A9_A0,
  output logic                 cmd_valid,
  output command_type          cmd,
  output logic [1:0]           bg_out,
  output logic [1:0]           ba_out,
  output logic [13:0]          row_out,
  output logic [9:0]           col_out,
  output logic                 ap_out,
  output logic                 bc_n_out,
  output logic                 mr_valid,
  output logic [17:0]          mode_reg,
  output logic                 err_valid,
  output err_type              err_code,
  output logic [NUM_BANKS-1:0] bank_open
);

  command_type      w_cmd;
  logic [ROW_W-1:0] w_row;
  logic [3:0]       w_bank;
  logic             w_valid;
  logic             w_is_cas;
  logic [ROW_W-1:0] w_open_row;
  logic             w_unused;

  logic             r_cmd_valid;
  command_type      r_cmd;
  logic [1:0]       r_bg;
  logic [1:0]       r_ba;
  logic [13:0]      r_row;
  logic [9:0]       r_col;
  logic             r_ap;
  logic             r_bcn;
  logic             r_mr_valid;
  logic [17:0]      r_mode_reg;

  // A17 is not part of the 14-bit row this decoder reports.
  assign w_unused = A17;

  assign w_row  = {A13, A12_BC_n, A11, A10_AP, A9_A0};
  assign w_bank = {bg_addr, ba_addr};

  always_comb begin
    w_cmd = CMD_NOP;
    if (cs_n) begin
      w_cmd = CMD_DES;
    end else if (!act_n) begin
      w_cmd = CMD_ACT;
    end else begin
      case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
        3'b000:  w_cmd = CMD_MRS;
        3'b001:  w_cmd = CMD_REF;
        3'b010:  w_cmd = A10_AP ? CMD_PREA : CMD_PRE;
        3'b011:  w_cmd = CMD_ILLEGAL;
        3'b100:  w_cmd = A10_AP ? CMD_WRA : CMD_WR;
        3'b101:  w_cmd = A10_AP ? CMD_RDA : CMD_RD;
        3'b110:  w_cmd = CMD_ZQCL;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  assign w_valid  = (w_cmd != CMD_DES) && (w_cmd != CMD_NOP);
  assign w_is_cas = is_cas(w_cmd);

  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_bg        <= '0;
      r_ba        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_ap        <= 1'b0;
      r_bcn       <= 1'b0;
      r_mr_valid  <= 1'b0;
      r_mode_reg  <= '0;
    end else begin
      r_cmd_valid <= w_valid;
      r_cmd       <= w_cmd;
      // Fields are zeroed for DES/NOP so don't-care pins never leak out.
      r_bg        <= w_valid ? bg_addr : '0;
      r_ba        <= w_valid ? ba_addr : '0;
      // Column commands report the row currently open in the target bank.
      r_row       <= (w_cmd == CMD_ACT) ? w_row : (w_is_cas ? w_open_row : '0);
      r_col       <= w_is_cas ? A9_A0 : '0;
      r_ap        <= w_is_cas & A10_AP;
      r_bcn       <= w_is_cas & A12_BC_n;
      r_mr_valid  <= (w_cmd == CMD_MRS);
      r_mode_reg  <= (w_cmd == CMD_MRS) ? {bg_addr[0], ba_addr, 1'b0, w_row} : '0;
    end
  end

  ddr_bank_tracker #(
    .TRCD      (TRCD),
    .NUM_BANKS (NUM_BANKS)
  ) u_bank_tracker (
    .i_clk       (CK_t),
    .i_rst_n     (reset_n),
    .i_cmd       (w_cmd),
    .i_bank      (w_bank),
    .i_row       (w_row),
    .o_open_row  (w_open_row),
    .o_bank_open (bank_open),
    .o_err_valid (err_valid),
    .o_err_code  (err_code)
  );

  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign bg_out    = r_bg;
  assign ba_out    = r_ba;
  assign row_out   = r_row;
  assign col_out   = r_col;
  assign ap_out    = r_ap;
  assign bc_n_out  = r_bcn;
  assign mr_valid  = r_mr_valid;
  assign mode_reg  = r_mode_reg;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_ddr_cmd_decoder
// Self-checking bench for ddr_cmd_decoder: a table of stateless decode vectors
// followed by hand-written multi-cycle sequences for bank timing and errors.
// Each driven cycle pushes its expectation onto a scoreboard queue, which is
// popped and compared after the edge that registers the result.
// -----------------------------------------------------------------------------
module tb_ddr_cmd_decoder;
  import ddr_cmd_decoder_pkg::*;

  typedef struct packed {
    logic       rst_n;
    logic       cs_n;
    logic       act_n;
    logic [2:0] rcw;
    logic [3:0] bank;
    logic [13:0] a;
  } pin_t;

  typedef struct packed {
    logic        valid;
    command_type cmd;
    logic        ev;
    err_type     ec;
    logic        mrv;
    logic        chk_open;
    logic [15:0] open;
    logic        chk_mr;
    logic [17:0] mr;
    logic        chk_cas;
    logic [9:0]  col;
    logic        ap;
    logic        bcn;
    logic        chk_row;
    logic [13:0] row;
    logic        chk_bank;
    logic [1:0]  bg;
    logic [1:0]  ba;
  } exp_t;

  typedef struct packed {
    pin_t p;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  bg_addr, ba_addr;
  logic        A17, A13, A12_BC_n, A11, A10_AP;
  logic [9:0]  A9_A0;
  logic        cmd_valid;
  command_type cmd;
  logic [1:0]  bg_out, ba_out;
  logic [13:0] row_out;
  logic [9:0]  col_out;
  logic        ap_out, bc_n_out, mr_valid, err_valid;
  logic [17:0] mode_reg;
  err_type     err_code;
  logic [15:0] bank_open;

  int   total  = 0;
  int   passed = 0;
  exp_t sb[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  ddr_cmd_decoder dut (
    .CK_t(clk), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .A17(A17), .A13(A13),
    .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .cmd_valid(cmd_valid), .cmd(cmd), .bg_out(bg_out), .ba_out(ba_out),
    .row_out(row_out), .col_out(col_out), .ap_out(ap_out), .bc_n_out(bc_n_out),
    .mr_valid(mr_valid), .mode_reg(mode_reg), .err_valid(err_valid),
    .err_code(err_code), .bank_open(bank_open)
  );

  // ---------------- stimulus builders ----------------
  function automatic pin_t p_cmd(input logic [2:0] rcw, input logic [3:0] bank, input logic [13:0] a);
    pin_t p;
    p = '0;
    p.rst_n = 1'b1;
    p.cs_n  = 1'b0;
    p.act_n = 1'b1;
    p.rcw   = rcw;
    p.bank  = bank;
    p.a     = a;
    return p;
  endfunction

  function automatic pin_t p_des();
    pin_t p;
    p = 'x;
    p.rst_n = 1'b1;
    p.cs_n  = 1'b1;
    return p;
  endfunction

  function automatic pin_t p_act(input logic [3:0] bank, input logic [13:0] row);
    pin_t p;
    p = p_cmd(3'b111, bank, row);
    p.act_n = 1'b0;
    return p;
  endfunction

  // RD/WR with BC_n=1 (BL8); A13 and A11 held low.
  function automatic pin_t p_rd(input logic [3:0] bank, input logic [9:0] col, input logic ap);
    return p_cmd(3'b101, bank, {1'b0, 1'b1, 1'b0, ap, col});
  endfunction

  function automatic pin_t p_wr(input logic [3:0] bank, input logic [9:0] col, input logic ap);
    return p_cmd(3'b100, bank, {1'b0, 1'b1, 1'b0, ap, col});
  endfunction

  // ---------------- expectation builders ----------------
  function automatic exp_t e_ok(input command_type c, input logic v);
    exp_t e;
    e = '0;
    e.cmd   = c;
    e.valid = v;
    e.ec    = ERR_NONE;
    return e;
  endfunction

  function automatic exp_t e_err(input command_type c, input err_type ec);
    exp_t e;
    e = e_ok(c, 1'b1);
    e.ev = 1'b1;
    e.ec = ec;
    return e;
  endfunction

  function automatic exp_t op(input exp_t ein, input logic [15:0] m);
    exp_t e;
    e = ein;
    e.chk_open = 1'b1;
    e.open     = m;
    return e;
  endfunction

  function automatic exp_t e_cas(input command_type c, input logic [9:0] col, input logic ap, input logic [15:0] m);
    exp_t e;
    e = op(e_ok(c, 1'b1), m);
    e.chk_cas = 1'b1;
    e.col     = col;
    e.ap      = ap;
    e.bcn     = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_mrs(input logic [17:0] mr);
    exp_t e;
    e = op(e_ok(CMD_MRS, 1'b1), 16'h0000);
    e.mrv    = 1'b1;
    e.chk_mr = 1'b1;
    e.mr     = mr;
    return e;
  endfunction

  function automatic exp_t e_rst();
    exp_t e;
    e = op(e_ok(CMD_NOP, 1'b0), 16'h0000);
    e.chk_mr   = 1'b1;
    e.chk_cas  = 1'b1;
    e.chk_row  = 1'b1;
    e.chk_bank = 1'b1;
    return e;
  endfunction

  // ---------------- drive / compare ----------------
  task automatic check_next(input string nm);
    exp_t x;
    logic ok;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
      return;
    end
    x  = sb.pop_front();
    ok = (cmd_valid === x.valid) && (cmd === x.cmd) && (err_valid === x.ev) &&
         (err_code === x.ec) && (mr_valid === x.mrv);
    if (x.chk_open) ok &= (bank_open === x.open);
    if (x.chk_mr)   ok &= (mode_reg === x.mr);
    if (x.chk_cas)  ok &= (col_out === x.col) && (ap_out === x.ap) && (bc_n_out === x.bcn);
    if (x.chk_row)  ok &= (row_out === x.row);
    if (x.chk_bank) ok &= (bg_out === x.bg) && (ba_out === x.ba);
    if (ok) begin
      passed++;
      $display("ok   %s: cmd=%0d valid=%0b err=%0b/%0d open=%h", nm, cmd, cmd_valid, err_valid, err_code, bank_open);
    end else begin
      $display("FAIL %s: got valid=%0b cmd=%0d err=%0b/%0d mr=%0b open=%h mode=%h col=%h ap=%0b bcn=%0b row=%h bg=%0d ba=%0d | want valid=%0b cmd=%0d err=%0b/%0d mr=%0b open=%h mode=%h col=%h ap=%0b bcn=%0b row=%h bg=%0d ba=%0d",
               nm, cmd_valid, cmd, err_valid, err_code, mr_valid, bank_open, mode_reg, col_out, ap_out, bc_n_out, row_out, bg_out, ba_out,
               x.valid, x.cmd, x.ev, x.ec, x.mrv, x.open, x.mr, x.col, x.ap, x.bcn, x.row, x.bg, x.ba);
    end
  endtask

  task automatic xact(input string nm, input pin_t p, input exp_t e);
    @(negedge clk);
    reset_n   = p.rst_n;
    cs_n      = p.cs_n;
    act_n     = p.act_n;
    {RAS_n_A16, CAS_n_A15, WE_n_A14} = p.rcw;
    {bg_addr, ba_addr} = p.bank;
    A17       = 1'b0;
    {A13, A12_BC_n, A11, A10_AP, A9_A0} = p.a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_next(nm);
  endtask

  task automatic idle(input int n, input logic [15:0] m);
    for (int k = 0; k < n; k++) begin
      xact("des", p_des(), op(e_ok(CMD_DES, 1'b0), m));
    end
  endtask

  initial begin
    exp_t e;
    pin_t p;

    reset_n = 1'b0;
    cs_n    = 1'b1;

    // Reset state
    p = p_des();
    p.rst_n = 1'b0;
    xact("reset0", p, e_rst());
    xact("reset1", p, e_rst());

    // Stateless decodes against an all-closed table
    vecs[0]  = '{p: p_des(),                              e: op(e_ok(CMD_DES, 1'b0), 16'h0)};
    vecs[1]  = '{p: p_cmd(3'b111, 4'h0, 14'h0),           e: op(e_ok(CMD_NOP, 1'b0), 16'h0)};
    vecs[2]  = '{p: p_cmd(3'b000, 4'h1, 14'h0010),        e: e_mrs(18'h08010)};
    vecs[3]  = '{p: p_cmd(3'b000, 4'hE, 14'h3FFF),        e: e_mrs(18'h33FFF)};
    vecs[4]  = '{p: p_cmd(3'b001, 4'h0, 14'h0),           e: op(e_ok(CMD_REF, 1'b1), 16'h0)};
    vecs[5]  = '{p: p_cmd(3'b110, 4'h0, 14'h0),           e: op(e_ok(CMD_ZQCL, 1'b1), 16'h0)};
    vecs[6]  = '{p: p_cmd(3'b010, 4'h7, 14'h0000),        e: op(e_ok(CMD_PRE, 1'b1), 16'h0)};
    vecs[7]  = '{p: p_cmd(3'b010, 4'h0, 14'h0400),        e: op(e_ok(CMD_PREA, 1'b1), 16'h0)};
    vecs[8]  = '{p: p_cmd(3'b011, 4'h0, 14'h0),           e: op(e_err(CMD_ILLEGAL, ERR_ILLEGAL), 16'h0)};
    vecs[9]  = '{p: p_rd(4'h4, 10'h001, 1'b0),            e: op(e_err(CMD_RD, ERR_CAS_CLOSED), 16'h0)};
    vecs[10] = '{p: p_wr(4'h9, 10'h002, 1'b0),            e: op(e_err(CMD_WR, ERR_CAS_CLOSED), 16'h0)};
    vecs[11] = '{p: p_rd(4'hC, 10'h003, 1'b1),            e: op(e_err(CMD_RDA, ERR_CAS_CLOSED), 16'h0)};
    for (int i = 0; i < 12; i++) begin
      xact($sformatf("vec%0d", i), vecs[i].p, vecs[i].e);
    end

    // ACT bg=1 ba=2 row 0x1ABC, RD col 0x055 exactly tRCD later
    e = op(e_ok(CMD_ACT, 1'b1), 16'h0040);
    e.chk_row = 1'b1; e.row = 14'h1ABC;
    e.chk_bank = 1'b1; e.bg = 2'd1; e.ba = 2'd2;
    xact("act_b6", p_act(4'h6, 14'h1ABC), e);
    idle(10, 16'h0040);
    xact("rd_b6", p_rd(4'h6, 10'h055, 1'b0), e_cas(CMD_RD, 10'h055, 1'b0, 16'h0040));

    // tRCD violations at 5 and 10 cycles, clean at 11
    xact("act_b0", p_act(4'h0, 14'h0123), op(e_ok(CMD_ACT, 1'b1), 16'h0041));
    idle(4, 16'h0041);
    xact("rd_b0_t5", p_rd(4'h0, 10'h010, 1'b0), op(e_err(CMD_RD, ERR_TRCD), 16'h0041));
    idle(4, 16'h0041);
    xact("rd_b0_t10", p_rd(4'h0, 10'h011, 1'b0), op(e_err(CMD_RD, ERR_TRCD), 16'h0041));
    xact("rd_b0_t11", p_rd(4'h0, 10'h012, 1'b0), e_cas(CMD_RD, 10'h012, 1'b0, 16'h0041));
    // ACT to an open bank is rejected and must not restart its timer
    xact("act_b0_open", p_act(4'h0, 14'h0456), op(e_err(CMD_ACT, ERR_ACT_OPEN), 16'h0041));
    xact("rd_b0_after", p_rd(4'h0, 10'h013, 1'b0), e_cas(CMD_RD, 10'h013, 1'b0, 16'h0041));

    // WRA closes bank 3 at the edge it is reported; RD then sees it closed
    xact("act_b3", p_act(4'h3, 14'h0777), op(e_ok(CMD_ACT, 1'b1), 16'h0049));
    idle(10, 16'h0049);
    xact("wra_b3", p_wr(4'h3, 10'h3FF, 1'b1), e_cas(CMD_WRA, 10'h3FF, 1'b1, 16'h0041));
    xact("rd_b3_closed", p_rd(4'h3, 10'h000, 1'b0), op(e_err(CMD_RD, ERR_CAS_CLOSED), 16'h0041));
    xact("rda_b6", p_rd(4'h6, 10'h000, 1'b1), e_cas(CMD_RDA, 10'h000, 1'b1, 16'h0001));

    // Refresh with banks open, then precharge and refresh cleanly
    xact("act_b5", p_act(4'h5, 14'h0042), op(e_ok(CMD_ACT, 1'b1), 16'h0021));
    xact("ref_open", p_cmd(3'b001, 4'h0, 14'h0), op(e_err(CMD_REF, ERR_REF_OPEN), 16'h0021));
    xact("zqcl_open", p_cmd(3'b110, 4'h0, 14'h0), op(e_err(CMD_ZQCL, ERR_REF_OPEN), 16'h0021));
    xact("pre_b0", p_cmd(3'b010, 4'h0, 14'h0), op(e_ok(CMD_PRE, 1'b1), 16'h0020));
    xact("pre_b0_closed", p_cmd(3'b010, 4'h0, 14'h0), op(e_ok(CMD_PRE, 1'b1), 16'h0020));
    xact("prea", p_cmd(3'b010, 4'h0, 14'h0400), op(e_ok(CMD_PREA, 1'b1), 16'h0000));
    xact("ref_clean", p_cmd(3'b001, 4'h0, 14'h0), op(e_ok(CMD_REF, 1'b1), 16'h0000));

    // Mid-operation reset discards the table
    xact("act_b2", p_act(4'h2, 14'h0100), op(e_ok(CMD_ACT, 1'b1), 16'h0004));
    idle(3, 16'h0004);
    p = p_rd(4'h2, 10'h020, 1'b0);
    p.rst_n = 1'b0;
    xact("reset_mid", p, e_rst());
    xact("rd_b2_post_rst", p_rd(4'h2, 10'h021, 1'b0), op(e_err(CMD_RD, ERR_CAS_CLOSED), 16'h0000));
    xact("illegal", p_cmd(3'b011, 4'h2, 14'h0), op(e_err(CMD_ILLEGAL, ERR_ILLEGAL), 16'h0000));
    xact("act_b2_again", p_act(4'h2, 14'h0200), op(e_ok(CMD_ACT, 1'b1), 16'h0004));
    xact("rd_b2_early", p_rd(4'h2, 10'h022, 1'b0), op(e_err(CMD_RD, ERR_TRCD), 16'h0004));
    idle(2, 16'h0004);

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_decoder.md
DDR_CMD_DECODER -- requirements
Module: ddr_cmd_decoder

Interface
REQ-001 SHALL have parameter TRCD, default 11, meaning minimum CK_t cycles from ACT to RD/WR/RDA/WRA on the same bank.
REQ-002 SHALL have parameter NUM_BANKS, default 16, meaning bank count indexed {bg_addr, ba_addr}.
REQ-003 SHALL have port CK_t  input  1  clock, all logic on rising edge; one clock, no other clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have DDR4 command-pin inputs: cs_n 1, act_n 1, RAS_n_A16 1, CAS_n_A15 1, WE_n_A14 1, bg_addr 2, ba_addr 2, A17 1, A13 1, A12_BC_n 1, A11 1, A10_AP 1, A9_A0 10.
REQ-006 SHALL have port cmd_valid  output  1  decoded non-DES/non-NOP command present.
REQ-007 SHALL have port cmd  output  command_type  decoded command.
REQ-008 SHALL have ports bg_out 2, ba_out 2, row_out 14, col_out 10, ap_out 1, bc_n_out 1, all outputs, meaning decoded fields.
REQ-009 SHALL have port mr_valid  output  1, and port mode_reg  output  18  MRS payload.
REQ-010 SHALL have port err_valid  output  1, and port err_code  output  err_type  protocol violation.
REQ-011 SHALL have port bank_open  output  NUM_BANKS  per-bank open-row flags.

Function
REQ-012 SHALL sample pins each rising CK_t and present registered outputs one cycle later (latency 1).
REQ-013 SHALL decode cs_n=1 as DES (other pins ignored, may be X), with cmd_valid=0.
REQ-014 SHALL decode cs_n=0, act_n=0 as ACT, with row_out = {A13, A12_BC_n, A11, A10_AP, A9_A0}.
REQ-015 SHALL decode cs_n=0, act_n=1 by {RAS,CAS,WE}: 000 MRS; 001 REF; 010 PRE if A10_AP=0, else PREA; 100 WR/WRA per A10_AP; 101 RD/RDA per A10_AP; 110 ZQCL; 111 NOP (cmd_valid=0); 011 ILLEGAL.
REQ-016 SHALL, for RD/WR/RDA/WRA, drive col_out=A9_A0, ap_out=A10_AP, and bc_n_out=A12_BC_n.
REQ-017 SHALL, on MRS, pulse mr_valid for one cycle with mode_reg[17:15]={bg_addr[0], ba_addr}, mode_reg[14]=0, and mode_reg[13:0]=row field.
REQ-018 SHALL keep a per-bank table: open flag, 14-bit open row, and tRCD down-counter.
REQ-019 SHALL, on legal ACT, set open, store row, and load counter with TRCD-1; each counter SHALL decrement every cycle and saturate at 0.
REQ-020 SHALL, on RD/WR, accept the command only if the bank is open and its counter is 0.
REQ-021 SHALL, on RDA/WRA, accept as RD/WR and then clear that bank's open flag at the same edge the outputs register.
REQ-022 SHALL, on PRE, clear the addressed bank; on PREA, clear all banks; PRE to a closed bank is legal and produces no error.
REQ-023 SHALL set errors, each a one-cycle err_valid pulse with cmd still reported and bank table unchanged: ACT to an open bank gives ERR_ACT_OPEN; CAS to a closed bank gives ERR_CAS_CLOSED; CAS with counter>0 gives ERR_TRCD; REF or ZQCL with any bank open gives ERR_REF_OPEN; ILLEGAL gives ERR_ILLEGAL.
REQ-024 SHALL hold err_code=ERR_NONE and err_valid=0 when no violation occurs.
REQ-025 SHALL drive bank_open directly from the table (registered, no added latency).

Reset
REQ-026 SHALL, while reset_n=0 at the clock edge, clear cmd_valid, mr_valid, and err_valid; set cmd=NOP and err_code=ERR_NONE; zero all field outputs, mode_reg, open flags, rows, and counters.
REQ-027 SHALL, on reset asserted mid-operation (banks open, counters running), discard all state at that edge; the first post-reset command SHALL be judged against an all-closed table.

Structure
REQ-028 SHALL take command_type from the shared DDR package and add err_type and TRCD default constant there.
REQ-029 SHALL use one sub-module ddr_bank_tracker holding the bank table, counters, and error checks; pin decode SHALL stay in the top level.

Verification
REQ-030 SHALL test: ACT bg=1 ba=2 row=0x1ABC, then RD col=0x055 after 11 cycles -> ACT then RD reported, bank_open[6]=1, no error.
REQ-031 SHALL test: ACT bank 0, then RD bank 0 after 5 cycles -> err_valid=1 with ERR_TRCD; RD at cycle 11 -> no error.
REQ-032 SHALL test: WRA bank 3 with valid timing -> cmd=WRA, ap_out=1, bank_open[3]=0 next cycle; subsequent RD bank 3 -> ERR_CAS_CLOSED.
REQ-033 SHALL test: MRS bg=0 ba=1 row=0x0010 -> mr_valid=1, mode_reg=18'h08010.
REQ-034 SHALL test: open banks 0 and 5, then REF -> ERR_REF_OPEN; then PREA then REF -> bank_open=0, no error.
REQ-035 SHALL test: open bank 2, reset_n=0 for one cycle, then RD bank 2 -> ERR_CAS_CLOSED; RAS/CAS/WE=011 -> ERR_ILLEGAL.
